// File: rtl/imm_rot_encoder_pkg.sv
// Shared types and helpers for the rotated-immediate encoder.
`timescale 1ns/1ps
package imm_rot_encoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int ROT_COUNT   = 16;
  localparam int IMM_FIELD_W = 12;

  // 32-bit rotate left; the upper half of the doubled word shifted left is the rotation.
  function automatic logic [31:0] rol32(input logic [31:0] value, input logic [4:0] amt);
    logic [63:0] dbl;
    dbl = {value, value} << amt;
    return dbl[63:32];
  endfunction

endpackage

// File: rtl/imm_rot_check.sv
// Tests one rotation candidate: rotating left by 2r must leave only the low byte set.
`timescale 1ns/1ps
module imm_rot_check
  import imm_rot_encoder_pkg::*;
(
  input  logic [31:0] value,
  input  logic [3:0]  r,
  output logic        hit,
  output logic [7:0]  imm8
);

  logic [31:0] cand;

  assign cand = rol32(value, {r, 1'b0});
  assign hit  = (cand[31:8] == 24'd0);
  assign imm8 = cand[7:0];

endmodule

// File: rtl/imm_rot_encoder.sv
// Iterative encoder from a 32-bit constant to the ARM {rot, imm8} operand-2 field,
// one rotation candidate per cycle, with valid/ready request and response.
`timescale 1ns/1ps
module imm_rot_encoder
  import imm_rot_encoder_pkg::*;
#(
  parameter bit EARLY_EXIT = 1'b1,
  parameter int ROT_COUNT  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [31:0]            req_value,
  input  logic                   abort,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic                   encodable,
  output logic [3:0]             rot,
  output logic [7:0]             imm8,
  output logic [IMM_FIELD_W-1:0] data12
);

  state_t      state;
  logic [31:0] value_reg;
  logic [3:0]  r_reg;
  logic        found_reg;
  logic [3:0]  hit_rot_reg;
  logic [7:0]  hit_imm_reg;

  logic       cand_hit;
  logic [7:0] cand_imm;
  logic       last_r;
  logic       finish;

  imm_rot_check u_check (
    .value (value_reg),
    .r     (r_reg),
    .hit   (cand_hit),
    .imm8  (cand_imm)
  );

  assign last_r = (r_reg == 4'(ROT_COUNT - 1));
  assign finish = last_r || (EARLY_EXIT && cand_hit);
  // rot/imm8 are zeroed on a miss, so the concatenation already reads zero then.
  assign data12 = {rot, imm8};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      encodable   <= 1'b0;
      rot         <= 4'd0;
      imm8        <= 8'd0;
      value_reg   <= 32'd0;
      r_reg       <= 4'd0;
      found_reg   <= 1'b0;
      hit_rot_reg <= 4'd0;
      hit_imm_reg <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            value_reg <= req_value;
            r_reg     <= 4'd0;
            found_reg <= 1'b0;
            encodable <= 1'b0;
            rot       <= 4'd0;
            imm8      <= 8'd0;
            req_ready <= 1'b0;
            state     <= SEARCH;
          end
        end
        SEARCH: begin
          if (abort) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            encodable  <= 1'b0;
            rot        <= 4'd0;
            imm8       <= 8'd0;
          end else begin
            // Only the smallest rotation is kept when the full scan runs on.
            if (cand_hit && !found_reg) begin
              found_reg   <= 1'b1;
              hit_rot_reg <= r_reg;
              hit_imm_reg <= cand_imm;
            end
            if (finish) begin
              state      <= DONE;
              resp_valid <= 1'b1;
              if (found_reg) begin
                encodable <= 1'b1;
                rot       <= hit_rot_reg;
                imm8      <= hit_imm_reg;
              end else if (cand_hit) begin
                encodable <= 1'b1;
                rot       <= r_reg;
                imm8      <= cand_imm;
              end else begin
                encodable <= 1'b0;
                rot       <= 4'd0;
                imm8      <= 8'd0;
              end
            end else begin
              r_reg <= r_reg + 4'd1;
            end
          end
        end
        DONE: begin
          if (abort) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            encodable  <= 1'b0;
            rot        <= 4'd0;
            imm8       <= 8'd0;
          end else if (resp_ready) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imm_rot_encoder.sv
// Directed bench for imm_rot_encoder: one early-exit instance and one full-scan instance.
`timescale 1ns/1ps
module tb_imm_rot_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [1:0]  abort = 2'b00;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready = 2'b00;
  logic [1:0]  encodable;
  logic [31:0] req_value [2];
  logic [3:0]  rot [2];
  logic [7:0]  imm8 [2];
  logic [11:0] data12 [2];

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  imm_rot_encoder #(.EARLY_EXIT(1'b1)) dut_early (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_value(req_value[0]),
    .abort(abort[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .encodable(encodable[0]), .rot(rot[0]), .imm8(imm8[0]), .data12(data12[0])
  );

  imm_rot_encoder #(.EARLY_EXIT(1'b0)) dut_full (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_value(req_value[1]),
    .abort(abort[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .encodable(encodable[1]), .rot(rot[1]), .imm8(imm8[1]), .data12(data12[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a request and return just after the accept edge.
  task automatic send(input int d, input logic [31:0] val);
    check("ready_before_req", 32'(req_ready[d]), 32'd1);
    req_value[d] = val;
    req_valid[d] = 1'b1;
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    check("ready_after_accept", 32'(req_ready[d]), 32'd0);
  endtask

  task automatic wait_resp(input int d, output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!resp_valid[d] && lat < 40);
    if (!resp_valid[d]) check("resp_timeout", 32'(resp_valid[d]), 32'd1);
  endtask

  task automatic expect_result(input int d, input logic [31:0] val, input logic enc,
                               input logic [3:0] erot, input logic [7:0] eimm, input int elat);
    int lat;
    logic [11:0] ed12;
    send(d, val);
    wait_resp(d, lat);
    ed12 = enc ? {erot, eimm} : 12'h000;
    $display("[TB] dut%0d value=%h enc=%0d rot=%0d imm8=%h data12=%h latency=%0d",
             d, val, encodable[d], rot[d], imm8[d], data12[d], lat);
    check("latency", 32'(lat), 32'(elat));
    check("encodable", 32'(encodable[d]), 32'(enc));
    check("rot", 32'(rot[d]), 32'(erot));
    check("imm8", 32'(imm8[d]), 32'(eimm));
    check("data12", 32'(data12[d]), 32'(ed12));
    check("ready_in_done", 32'(req_ready[d]), 32'd0);
  endtask

  task automatic release_resp(input int d);
    resp_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    resp_ready[d] = 1'b0;
    check("resp_cleared", 32'(resp_valid[d]), 32'd0);
    check("ready_after_resp", 32'(req_ready[d]), 32'd1);
  endtask

  initial begin
    int seen;
    req_value[0] = 32'd0;
    req_value[1] = 32'd0;

    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_req_ready", 32'(req_ready[d]), 32'd1);
      check("rst_resp_valid", 32'(resp_valid[d]), 32'd0);
      check("rst_encodable", 32'(encodable[d]), 32'd0);
      check("rst_data12", 32'(data12[d]), 32'd0);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Early-exit instance
    expect_result(0, 32'h0000_00FF, 1'b1, 4'd0, 8'hFF, 1);   release_resp(0);
    expect_result(0, 32'hFF00_0000, 1'b1, 4'd4, 8'hFF, 5);   release_resp(0);
    expect_result(0, 32'h0000_0101, 1'b0, 4'd0, 8'h00, 16);  release_resp(0);
    expect_result(0, 32'h0000_0000, 1'b1, 4'd0, 8'h00, 1);   release_resp(0);

    // Full-scan instance: constant latency, smallest rotation still reported
    expect_result(1, 32'hFF00_0000, 1'b1, 4'd4, 8'hFF, 16);  release_resp(1);
    expect_result(1, 32'h0000_00FF, 1'b1, 4'd0, 8'hFF, 16);  release_resp(1);
    expect_result(1, 32'h0000_0104, 1'b1, 4'd15, 8'h41, 16); release_resp(1);
    expect_result(1, 32'h0000_0101, 1'b0, 4'd0, 8'h00, 16);  release_resp(1);

    // Response held under back-pressure, then a back-to-back request
    expect_result(0, 32'h0000_0104, 1'b1, 4'd15, 8'h41, 16);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("hold_resp_valid", 32'(resp_valid[0]), 32'd1);
      check("hold_req_ready", 32'(req_ready[0]), 32'd0);
      check("hold_data12", 32'(data12[0]), 32'h0F41);
    end
    release_resp(0);
    expect_result(0, 32'h3FC0_0000, 1'b1, 4'd5, 8'hFF, 6);   release_resp(0);

    // abort beats resp_ready in DONE and clears the result
    expect_result(0, 32'h0000_00FF, 1'b1, 4'd0, 8'hFF, 1);
    abort[0] = 1'b1;
    resp_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    abort[0] = 1'b0;
    resp_ready[0] = 1'b0;
    check("abort_done_valid", 32'(resp_valid[0]), 32'd0);
    check("abort_done_ready", 32'(req_ready[0]), 32'd1);
    check("abort_done_data12", 32'(data12[0]), 32'd0);
    check("abort_done_enc", 32'(encodable[0]), 32'd0);

    // abort while testing rotation 3
    send(0, 32'h0000_0101);
    repeat (3) @(posedge clk);
    #1;
    abort[0] = 1'b1;
    @(posedge clk);
    #1;
    abort[0] = 1'b0;
    check("abort_search_ready", 32'(req_ready[0]), 32'd1);
    check("abort_search_valid", 32'(resp_valid[0]), 32'd0);
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (resp_valid[0]) seen = 1;
    end
    check("abort_no_resp", 32'(seen), 32'd0);
    $display("[TB] dut0 abort during search, req_ready=%0d", req_ready[0]);

    // Asynchronous reset mid-search, between clock edges
    send(0, 32'h0000_0101);
    repeat (4) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("arst_search_ready", 32'(req_ready[0]), 32'd1);
    check("arst_search_valid", 32'(resp_valid[0]), 32'd0);
    check("arst_search_data12", 32'(data12[0]), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    expect_result(0, 32'h0000_00FF, 1'b1, 4'd0, 8'hFF, 1);   release_resp(0);

    // Asynchronous reset while a result is held
    expect_result(1, 32'hFF00_0000, 1'b1, 4'd4, 8'hFF, 16);
    #2;
    reset = 1'b1;
    #1;
    check("arst_done_valid", 32'(resp_valid[1]), 32'd0);
    check("arst_done_data12", 32'(data12[1]), 32'd0);
    check("arst_done_enc", 32'(encodable[1]), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    expect_result(1, 32'h3FC0_0000, 1'b1, 4'd5, 8'hFF, 16);  release_resp(1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
